// File: rtl/multdiv_seq_ctrl_pkg.sv
// Shared constants and state encoding for the mul/div sequencing controller.
package multdiv_seq_ctrl_pkg;

   localparam int unsigned REG_W      = 5;
   localparam int unsigned RSTATUS_W  = 32;
   localparam int unsigned ALU_OP_W   = 5;

   // Controller states
   typedef enum logic [1:0] {
      MD_IDLE  = 2'd0,
      MD_ISSUE = 2'd1,
      MD_WAIT  = 2'd2,
      MD_DONE  = 2'd3
   } md_state_e;

   localparam logic [REG_W-1:0]     REG_RSTATUS     = REG_W'(30);
   localparam logic [RSTATUS_W-1:0] RSTATUS_MUL_OVF = RSTATUS_W'(4);
   localparam logic [RSTATUS_W-1:0] RSTATUS_DIV_EXC = RSTATUS_W'(5);

   localparam logic [ALU_OP_W-1:0]  ALU_OP_MUL      = 5'b00110;
   localparam logic [ALU_OP_W-1:0]  ALU_OP_DIV      = 5'b00111;

   // rstatus code reported when a mul/div op ends in error
   function automatic logic [RSTATUS_W-1:0] md_err_code(input logic is_div);
      return is_div ? RSTATUS_DIV_EXC : RSTATUS_MUL_OVF;
   endfunction

endpackage

// File: rtl/multdiv_seq_ctrl_md_wait_counter.sv
// Saturating WAIT-cycle counter; hit flags the last allowed WAIT cycle.
module md_wait_counter #(
   parameter int unsigned TIMEOUT = 40,
   parameter int unsigned CNT_W   = 6
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic hit
);

   logic [CNT_W-1:0] count;

   // Count WAIT cycles, holding at all-ones rather than wrapping
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

   // Combinational so the FSM can leave WAIT in the same cycle the limit is reached
   assign hit = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Sequences the multi-cycle multiplier/divider for a mul/div op in execute:
// stalls the pipe, strobes the unit once, waits for ready or timeout, then
// issues a single writeback to rd or to $r30 with an rstatus code.
module multdiv_seq_ctrl
   import multdiv_seq_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 40,
   parameter int unsigned CNT_W   = 6
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 md_valid,
   input  logic                 md_is_div,
   input  logic [REG_W-1:0]     md_rd,
   input  logic                 flush,
   input  logic                 md_ready,
   input  logic                 md_exc,
   output logic                 ctrl_MULT,
   output logic                 ctrl_DIV,
   output logic                 stall,
   output logic                 wb_en,
   output logic [REG_W-1:0]     wb_rd,
   output logic                 wb_sel_rstatus,
   output logic [RSTATUS_W-1:0] rstatus_val,
   output logic                 timeout_err
);

   md_state_e        state;
   logic [REG_W-1:0] rd_q;
   logic             is_div_q;
   logic             cnt_hit;
   logic             done_err_c;

   // Counter is cleared while strobing and advances once per WAIT cycle
   md_wait_counter #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_wait_cnt (
      .clock  (clock),
      .reset  (reset),
      .clear  (state == MD_ISSUE),
      .enable (state == MD_WAIT),
      .hit    (cnt_hit)
   );

   // Completion is an error on exception, or when the timeout ends WAIT without ready
   assign done_err_c = md_ready ? md_exc : 1'b1;

   // Stall raised the same cycle a new op is seen so execute holds it; dropped in DONE
   assign stall = ((state == MD_IDLE) && md_valid && !flush) ||
                  (state == MD_ISSUE) || (state == MD_WAIT);

   // State register and registered outputs; pulse outputs default low every cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= MD_IDLE;
         rd_q           <= '0;
         is_div_q       <= 1'b0;
         ctrl_MULT      <= 1'b0;
         ctrl_DIV       <= 1'b0;
         wb_en          <= 1'b0;
         wb_rd          <= '0;
         wb_sel_rstatus <= 1'b0;
         rstatus_val    <= '0;
         timeout_err    <= 1'b0;
      end else begin
         ctrl_MULT      <= 1'b0;
         ctrl_DIV       <= 1'b0;
         wb_en          <= 1'b0;
         wb_rd          <= '0;
         wb_sel_rstatus <= 1'b0;
         rstatus_val    <= '0;

         case (state)
            MD_IDLE: begin
               if (md_valid && !flush) begin
                  state     <= MD_ISSUE;
                  rd_q      <= md_rd;
                  is_div_q  <= md_is_div;
                  ctrl_DIV  <= md_is_div;
                  ctrl_MULT <= !md_is_div;
               end
            end
            MD_ISSUE: begin
               state <= flush ? MD_IDLE : MD_WAIT;
            end
            MD_WAIT: begin
               if (flush) begin
                  state <= MD_IDLE;
               end else if (md_ready || cnt_hit) begin
                  state          <= MD_DONE;
                  wb_en          <= done_err_c || (rd_q != '0);
                  wb_rd          <= done_err_c ? REG_RSTATUS : rd_q;
                  wb_sel_rstatus <= done_err_c;
                  rstatus_val    <= done_err_c ? md_err_code(is_div_q) : '0;
                  if (!md_ready) begin
                     timeout_err <= 1'b1;
                  end
               end
            end
            MD_DONE: begin
               state <= MD_IDLE;
            end
            default: begin
               state <= MD_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Directed bench for multdiv_seq_ctrl.
module tb_multdiv_seq_ctrl;

   localparam int unsigned TIMEOUT = 40;

   logic        clock;
   logic        reset;
   logic        md_valid;
   logic        md_is_div;
   logic [4:0]  md_rd;
   logic        flush;
   logic        md_ready;
   logic        md_exc;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic        stall;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic        wb_sel_rstatus;
   logic [31:0] rstatus_val;
   logic        timeout_err;

   int checks   = 0;
   int failures = 0;

   multdiv_seq_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
      .clock          (clock),
      .reset          (reset),
      .md_valid       (md_valid),
      .md_is_div      (md_is_div),
      .md_rd          (md_rd),
      .flush          (flush),
      .md_ready       (md_ready),
      .md_exc         (md_exc),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .stall          (stall),
      .wb_en          (wb_en),
      .wb_rd          (wb_rd),
      .wb_sel_rstatus (wb_sel_rstatus),
      .rstatus_val    (rstatus_val),
      .timeout_err    (timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance to just after the next rising edge; inputs are driven here
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // Present an op in IDLE and step into its ISSUE cycle
   task automatic start_op(input logic is_div, input logic [4:0] rd);
      md_valid  = 1'b1;
      md_is_div = is_div;
      md_rd     = rd;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      #1;
      checks++;
      if ({ctrl_MULT, ctrl_DIV, stall, wb_en, wb_sel_rstatus, timeout_err} !== 6'b0 ||
          wb_rd !== 5'd0 || rstatus_val !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs: got mult=%b div=%b stall=%b wb_en=%b rd=%0d sel=%b rs=%0d terr=%b want all 0",
                  ctrl_MULT, ctrl_DIV, stall, wb_en, wb_rd, wb_sel_rstatus, rstatus_val, timeout_err);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_mul_normal();
      int mul_cnt;
      int stall_low;
      mul_cnt   = 0;
      stall_low = 0;
      md_valid = 1'b1; md_is_div = 1'b0; md_rd = 5'd5;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("FAIL mul_stall_idle: got %b want 1", stall);
      end
      tick();
      #1;
      checks++;
      if (ctrl_MULT !== 1'b1 || ctrl_DIV !== 1'b0) begin
         failures++;
         $display("FAIL mul_strobe: got mult=%b div=%b want 1/0", ctrl_MULT, ctrl_DIV);
      end
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 8) md_ready = 1'b1;
         #1;
         if (ctrl_MULT) mul_cnt++;
         if (!stall || wb_en) stall_low++;
      end
      checks++;
      if (mul_cnt !== 0 || stall_low !== 0) begin
         failures++;
         $display("FAIL mul_wait: got extra_strobes=%0d stall_low_or_wb=%0d want 0/0", mul_cnt, stall_low);
      end
      tick();
      md_ready = 1'b0;
      md_valid = 1'b0;
      #1;
      checks++;
      if (wb_en !== 1'b1 || wb_rd !== 5'd5 || wb_sel_rstatus !== 1'b0 ||
          rstatus_val !== 32'd0 || stall !== 1'b0) begin
         failures++;
         $display("FAIL mul_done: got wb_en=%b rd=%0d sel=%b rs=%0d stall=%b want 1/5/0/0/0",
                  wb_en, wb_rd, wb_sel_rstatus, rstatus_val, stall);
      end
      tick();
      #1;
      checks++;
      if (wb_en !== 1'b0 || stall !== 1'b0) begin
         failures++;
         $display("FAIL mul_after: got wb_en=%b stall=%b want 0/0", wb_en, stall);
      end
   endtask

   task automatic test_div_exc();
      int mul_cnt;
      int div_cnt;
      mul_cnt = 0;
      div_cnt = 0;
      start_op(1'b1, 5'd7);
      #1;
      if (ctrl_MULT) mul_cnt++;
      if (ctrl_DIV) div_cnt++;
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (i == 3) begin md_ready = 1'b1; md_exc = 1'b1; end
         #1;
         if (ctrl_MULT) mul_cnt++;
         if (ctrl_DIV) div_cnt++;
      end
      tick();
      md_ready = 1'b0; md_exc = 1'b0; md_valid = 1'b0;
      #1;
      if (ctrl_MULT) mul_cnt++;
      if (ctrl_DIV) div_cnt++;
      checks++;
      if (wb_en !== 1'b1 || wb_rd !== 5'd30 || wb_sel_rstatus !== 1'b1 || rstatus_val !== 32'd5) begin
         failures++;
         $display("FAIL div_exc_done: got wb_en=%b rd=%0d sel=%b rs=%0d want 1/30/1/5",
                  wb_en, wb_rd, wb_sel_rstatus, rstatus_val);
      end
      checks++;
      if (div_cnt !== 1 || mul_cnt !== 0) begin
         failures++;
         $display("FAIL div_strobes: got div=%0d mul=%0d want 1/0", div_cnt, mul_cnt);
      end
      checks++;
      if (timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL div_no_timeout: got %b want 0", timeout_err);
      end
      tick();
   endtask

   task automatic test_rd_zero();
      start_op(1'b0, 5'd0);
      tick();
      md_ready = 1'b1;
      tick();
      md_ready = 1'b0; md_valid = 1'b0;
      #1;
      checks++;
      if (wb_en !== 1'b0 || wb_sel_rstatus !== 1'b0 || stall !== 1'b0) begin
         failures++;
         $display("FAIL rd_zero: got wb_en=%b sel=%b stall=%b want 0/0/0", wb_en, wb_sel_rstatus, stall);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int mul_cnt;
      int wb_cnt;
      logic [4:0] rds [2];
      mul_cnt = 0;
      wb_cnt  = 0;
      rds[0]  = '0;
      rds[1]  = '0;
      for (int c = 0; c <= 10; c++) begin
         md_ready = 1'b0;
         case (c)
            0: begin md_valid = 1'b1; md_is_div = 1'b0; md_rd = 5'd3; end
            3: md_ready = 1'b1;
            4: begin md_valid = 1'b1; md_rd = 5'd4; end
            7: md_ready = 1'b1;
            9: md_valid = 1'b0;
            default: ;
         endcase
         #1;
         if (ctrl_MULT) mul_cnt++;
         if (wb_en) begin
            if (wb_cnt < 2) rds[wb_cnt] = wb_rd;
            wb_cnt++;
            checks++;
            if (c != 4 && c != 8) begin
               failures++;
               $display("FAIL b2b_wb_cycle: got wb_en at cycle %0d want cycles 4 and 8", c);
            end
         end
         tick();
      end
      checks++;
      if (mul_cnt !== 2 || wb_cnt !== 2) begin
         failures++;
         $display("FAIL b2b_counts: got strobes=%0d wb=%0d want 2/2", mul_cnt, wb_cnt);
      end
      checks++;
      if (rds[0] !== 5'd3 || rds[1] !== 5'd4) begin
         failures++;
         $display("FAIL b2b_rd: got %0d,%0d want 3,4", rds[0], rds[1]);
      end
   endtask

   task automatic test_flush();
      int bad;
      bad = 0;
      start_op(1'b0, 5'd6);
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (i == 3) flush = 1'b1;
      end
      tick();
      flush = 1'b0; md_valid = 1'b0; md_ready = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0 || wb_en !== 1'b0 || ctrl_MULT !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle: got stall=%b wb_en=%b mult=%b want 0/0/0", stall, wb_en, ctrl_MULT);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         if (stall || wb_en || ctrl_MULT || ctrl_DIV) bad++;
      end
      md_ready = 1'b0;
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL flush_late_ready: got %0d active cycles want 0", bad);
      end
      md_valid = 1'b1; md_is_div = 1'b0; md_rd = 5'd9; flush = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle_stall: got %b want 0", stall);
      end
      tick();
      #1;
      checks++;
      if (ctrl_MULT !== 1'b0 || stall !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle_stay: got mult=%b stall=%b want 0/0", ctrl_MULT, stall);
      end
      flush = 1'b0; md_valid = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      start_op(1'b0, 5'd9);
      for (int i = 1; i <= TIMEOUT; i++) begin
         tick();
         #1;
         if (wb_en || !stall || timeout_err) early++;
      end
      checks++;
      if (early !== 0) begin
         failures++;
         $display("FAIL timeout_wait_len: got %0d early-exit cycles want 0", early);
      end
      tick();
      md_valid = 1'b0;
      #1;
      checks++;
      if (wb_en !== 1'b1 || wb_rd !== 5'd30 || wb_sel_rstatus !== 1'b1 ||
          rstatus_val !== 32'd4 || timeout_err !== 1'b1) begin
         failures++;
         $display("FAIL timeout_done: got wb_en=%b rd=%0d sel=%b rs=%0d terr=%b want 1/30/1/4/1",
                  wb_en, wb_rd, wb_sel_rstatus, rstatus_val, timeout_err);
      end
      tick();
      start_op(1'b0, 5'd2);
      tick();
      md_ready = 1'b1;
      tick();
      md_ready = 1'b0; md_valid = 1'b0;
      #1;
      checks++;
      if (timeout_err !== 1'b1 || wb_en !== 1'b1 || wb_rd !== 5'd2 || wb_sel_rstatus !== 1'b0) begin
         failures++;
         $display("FAIL timeout_sticky: got terr=%b wb_en=%b rd=%0d sel=%b want 1/1/2/0",
                  timeout_err, wb_en, wb_rd, wb_sel_rstatus);
      end
      tick();
   endtask

   task automatic test_reset_mid_wait();
      int div_cnt;
      div_cnt = 0;
      start_op(1'b0, 5'd11);
      tick();
      tick();
      reset = 1'b1; md_valid = 1'b0;
      tick();
      #1;
      checks++;
      if ({ctrl_MULT, ctrl_DIV, stall, wb_en, wb_sel_rstatus, timeout_err} !== 6'b0 ||
          wb_rd !== 5'd0 || rstatus_val !== 32'd0) begin
         failures++;
         $display("FAIL reset_mid_wait: got mult=%b div=%b stall=%b wb_en=%b rd=%0d terr=%b want all 0",
                  ctrl_MULT, ctrl_DIV, stall, wb_en, wb_rd, timeout_err);
      end
      reset = 1'b0;
      tick();
      start_op(1'b1, 5'd12);
      #1;
      if (ctrl_DIV) div_cnt++;
      tick();
      md_ready = 1'b1;
      tick();
      md_ready = 1'b0; md_valid = 1'b0;
      #1;
      checks++;
      if (div_cnt !== 1 || wb_en !== 1'b1 || wb_rd !== 5'd12 ||
          wb_sel_rstatus !== 1'b0 || rstatus_val !== 32'd0) begin
         failures++;
         $display("FAIL post_reset_op: got strobes=%0d wb_en=%b rd=%0d sel=%b rs=%0d want 1/1/12/0/0",
                  div_cnt, wb_en, wb_rd, wb_sel_rstatus, rstatus_val);
      end
      tick();
   endtask

   initial begin
      reset = 1'b1; md_valid = 1'b0; md_is_div = 1'b0; md_rd = '0;
      flush = 1'b0; md_ready = 1'b0; md_exc = 1'b0;
      test_reset();
      test_mul_normal();
      test_div_exc();
      test_rd_zero();
      test_back_to_back();
      test_flush();
      test_timeout();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
